// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S transmitter for the codec DAC path.
// Takes parallel stereo samples through a single-entry holding register and
// serializes them as BCLK/LRCLK/SDATA. Left channel is sent while LRCLK=0, and
// each MSB goes out one BCLK after the LRCLK edge. The block reports underrun
// (a frame loaded with no fresh sample) and overrun (a sample written over an
// unread one).
module i2s_dac_tx #(
  parameter int BCLK_DIV = 4,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                VALID,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  output logic                sample_req,
  output logic                underrun,
  output logic                overrun,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                SDATA
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int CNT_W = $clog2(2 * SLOT_W);
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(SAMPLE_W);

  logic [DIV_W-1:0]    r_div;
  logic                r_bclk;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_lrclk;
  logic                r_sdata;
  logic                r_sample_req;
  logic                r_underrun;
  logic                r_overrun;
  logic                r_hold_full;
  logic [SAMPLE_W-1:0] r_hold_l;
  logic [SAMPLE_W-1:0] r_hold_r;
  logic [SAMPLE_W-1:0] r_left_dat;
  logic [SAMPLE_W-1:0] r_right_dat;
  logic [SAMPLE_W-1:0] r_sh;

  logic                w_div_tc;
  logic                w_fall;
  logic [CNT_W-1:0]    w_b_next;
  logic                w_load;
  logic                w_slot;
  logic [CNT_W-1:0]    w_pos;
  logic [SAMPLE_W-1:0] w_left_new;
  logic [SAMPLE_W-1:0] w_right_new;

  // Bit-clock timing, next bit position and the data a frame load would latch.
  // At a load, a same-cycle VALID takes priority over the holding register.
  always_comb begin
    w_div_tc = (r_div == DIV_TC);
    w_fall   = w_div_tc && r_bclk;
    w_b_next = (r_bit_cnt == CNT_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
    w_load   = w_fall && (w_b_next == '0);
    w_slot   = (w_b_next >= SLOT_C);
    w_pos    = w_slot ? (w_b_next - SLOT_C) : w_b_next;
    if (VALID) begin
      w_left_new  = left_in;
      w_right_new = right_in;
    end else if (r_hold_full) begin
      w_left_new  = r_hold_l;
      w_right_new = r_hold_r;
    end else begin
      w_left_new  = r_left_dat;
      w_right_new = r_right_dat;
    end
  end

  // Divider, serializer, holding register and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div        <= '0;
      r_bclk       <= 1'b0;
      r_bit_cnt    <= CNT_LAST;
      r_lrclk      <= 1'b1;
      r_sdata      <= 1'b0;
      r_sample_req <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
      r_hold_full  <= 1'b0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_left_dat   <= '0;
      r_right_dat  <= '0;
      r_sh         <= '0;
    end else begin
      r_sample_req <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;

      if (w_div_tc) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end

      // Position 0 of each slot preloads the serializer; the next fall event
      // sends the MSB. At b=0 this uses the freshly latched left sample.
      if (w_fall) begin
        r_bit_cnt <= w_b_next;
        r_lrclk   <= w_slot;
        if (w_pos == '0) begin
          r_sdata <= 1'b0;
          r_sh    <= w_slot ? r_right_dat : w_left_new;
        end else if (w_pos <= SAMP_C) begin
          r_sdata <= r_sh[SAMPLE_W-1];
          r_sh    <= {r_sh[SAMPLE_W-2:0], 1'b0};
        end else begin
          r_sdata <= 1'b0;
        end
      end

      // A frame load drains the holding register. If nothing is waiting, the
      // previous sample pair is sent again and underrun is flagged.
      if (w_load) begin
        r_sample_req <= 1'b1;
        r_hold_full  <= 1'b0;
        r_left_dat   <= w_left_new;
        r_right_dat  <= w_right_new;
        if (!VALID && !r_hold_full) begin
          r_underrun <= 1'b1;
        end
      end else if (VALID) begin
        r_hold_l    <= left_in;
        r_hold_r    <= right_in;
        r_hold_full <= 1'b1;
        if (r_hold_full) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign BCLK       = r_bclk;
  assign LRCLK      = r_lrclk;
  assign SDATA      = r_sdata;
  assign sample_req = r_sample_req;
  assign underrun   = r_underrun;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed testbench for i2s_dac_tx with the default parameters.
module tb_i2s_dac_tx;

  logic        clk;
  logic        rst;
  logic        VALID;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        sample_req;
  logic        underrun;
  logic        overrun;
  logic        BCLK;
  logic        LRCLK;
  logic        SDATA;

  int tests;
  int failed;

  localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

  i2s_dac_tx dut (
    .clk(clk), .rst(rst), .VALID(VALID), .left_in(left_in), .right_in(right_in),
    .sample_req(sample_req), .underrun(underrun), .overrun(overrun),
    .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected SDATA frame, with b=0 in bit 63 and b=63 in bit 0.
  function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
  endfunction

  // Returns at the negedge where sample_req is visible.
  task automatic wait_load(output logic ur, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sample_req && cyc < 600);
    tests++;
    if (sample_req !== 1'b1) begin
      failed++;
      $display("FAIL wait_load: sample_req=%b after %0d clk, required 1", sample_req, cyc);
    end
    ur = underrun;
  endtask

  // Called at the load negedge. Samples on each BCLK rising edge for b=0..63.
  task automatic capture_frame(output logic [63:0] sd, output logic [63:0] lr);
    sd = '0;
    lr = '0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      if (i > 0) repeat (8) @(negedge clk);
      sd = {sd[62:0], SDATA};
      lr = {lr[62:0], LRCLK};
    end
  endtask

  task automatic write_sample(input logic [15:0] l, input logic [15:0] r, output logic ovr);
    @(negedge clk);
    VALID    = 1'b1;
    left_in  = l;
    right_in = r;
    @(negedge clk);
    ovr   = overrun;
    VALID = 1'b0;
  endtask

  task automatic test_reset;
    logic [63:0] sd, lr;
    logic        ur;
    logic        bclk_bad;
    int          cyc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({BCLK, LRCLK, SDATA, sample_req, underrun, overrun} !== 6'b010000) begin
      failed++;
      $display("FAIL reset_outputs: got %b, required 010000",
               {BCLK, LRCLK, SDATA, sample_req, underrun, overrun});
    end
    rst      = 1'b0;
    bclk_bad = 1'b0;
    cyc      = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (BCLK !== ((cyc >= 4 && cyc < 8) ? 1'b1 : 1'b0)) bclk_bad = 1'b1;
    end while (!sample_req && cyc < 20);
    ur = underrun;
    tests++;
    if (cyc != 8) begin
      failed++;
      $display("FAIL first_load_time: load after %0d clk, required 8", cyc);
    end
    tests++;
    if (bclk_bad) begin
      failed++;
      $display("FAIL bclk_period: BCLK not high for clk 4..7 after reset, required toggle every 4 clk");
    end
    tests++;
    if (ur !== 1'b1) begin
      failed++;
      $display("FAIL first_underrun: underrun=%b, required 1", ur);
    end
    capture_frame(sd, lr);
    tests++;
    if (sd !== 64'h0) begin
      failed++;
      $display("FAIL first_frame_sdata: got %h, required 0", sd);
    end
    tests++;
    if (lr !== LR_EXP) begin
      failed++;
      $display("FAIL lrclk_pattern: got %h, required %h", lr, LR_EXP);
    end
  endtask

  task automatic test_single;
    logic [63:0] sd, lr;
    logic        ur, ovr;
    int          cyc;
    wait_load(ur, cyc);
    repeat (100) @(negedge clk);
    write_sample(16'hA5F0, 16'h0F0F, ovr);
    tests++;
    if (ovr !== 1'b0) begin
      failed++;
      $display("FAIL single_overrun: overrun=%b, required 0", ovr);
    end
    wait_load(ur, cyc);
    tests++;
    if (ur !== 1'b0) begin
      failed++;
      $display("FAIL single_underrun: underrun=%b, required 0", ur);
    end
    capture_frame(sd, lr);
    tests++;
    if (sd !== exp_frame(16'hA5F0, 16'h0F0F)) begin
      failed++;
      $display("FAIL single_frame: got %h, required %h", sd, exp_frame(16'hA5F0, 16'h0F0F));
    end
    tests++;
    if (lr !== LR_EXP) begin
      failed++;
      $display("FAIL single_lrclk: got %h, required %h", lr, LR_EXP);
    end
  endtask

  task automatic test_overrun;
    logic [63:0] sd, lr;
    logic        ur, ovr;
    int          cyc;
    wait_load(ur, cyc);
    repeat (20) @(negedge clk);
    write_sample(16'h1234, 16'h5678, ovr);
    tests++;
    if (ovr !== 1'b0) begin
      failed++;
      $display("FAIL first_write_overrun: overrun=%b, required 0", ovr);
    end
    repeat (10) @(negedge clk);
    write_sample(16'h8001, 16'h7FFF, ovr);
    tests++;
    if (ovr !== 1'b1) begin
      failed++;
      $display("FAIL second_write_overrun: overrun=%b, required 1", ovr);
    end
    wait_load(ur, cyc);
    tests++;
    if (ur !== 1'b0) begin
      failed++;
      $display("FAIL overrun_load_underrun: underrun=%b, required 0", ur);
    end
    capture_frame(sd, lr);
    tests++;
    if (sd !== exp_frame(16'h8001, 16'h7FFF)) begin
      failed++;
      $display("FAIL last_wins_frame: got %h, required %h", sd, exp_frame(16'h8001, 16'h7FFF));
    end
  endtask

  task automatic test_underrun;
    logic [63:0] sd, lr;
    logic        ur, ovr;
    int          cyc;
    wait_load(ur, cyc);
    repeat (30) @(negedge clk);
    write_sample(16'h8001, 16'h7FFF, ovr);
    wait_load(ur, cyc);
    capture_frame(sd, lr);
    wait_load(ur, cyc);
    tests++;
    if (ur !== 1'b1) begin
      failed++;
      $display("FAIL repeat_underrun: underrun=%b, required 1", ur);
    end
    capture_frame(sd, lr);
    tests++;
    if (sd !== exp_frame(16'h8001, 16'h7FFF)) begin
      failed++;
      $display("FAIL repeat_frame: got %h, required %h", sd, exp_frame(16'h8001, 16'h7FFF));
    end
  endtask

  task automatic test_bypass;
    logic [63:0] sd, lr;
    logic        ur, ovr;
    int          cyc;
    wait_load(ur, cyc);
    repeat (20) @(negedge clk);
    write_sample(16'h1111, 16'h1111, ovr);
    repeat (488) @(negedge clk);
    // Drives VALID so the next posedge is exactly the frame-load edge.
    write_sample(16'hFFFF, 16'h0001, ovr);
    tests++;
    if ({sample_req, underrun, ovr} !== 3'b100) begin
      failed++;
      $display("FAIL bypass_flags: req/underrun/overrun=%b, required 100",
               {sample_req, underrun, ovr});
    end
    capture_frame(sd, lr);
    tests++;
    if (sd !== exp_frame(16'hFFFF, 16'h0001)) begin
      failed++;
      $display("FAIL bypass_frame: got %h, required %h", sd, exp_frame(16'hFFFF, 16'h0001));
    end
    wait_load(ur, cyc);
    tests++;
    if (ur !== 1'b1) begin
      failed++;
      $display("FAIL bypass_hold_empty: underrun=%b, required 1", ur);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] sd, lr;
    logic        ur;
    int          cyc;
    wait_load(ur, cyc);
    repeat (164) @(negedge clk);
    tests++;
    if ({BCLK, LRCLK} !== 2'b10) begin
      failed++;
      $display("FAIL pre_reset_state: BCLK/LRCLK=%b, required 10", {BCLK, LRCLK});
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({BCLK, LRCLK, SDATA, sample_req, underrun, overrun} !== 6'b010000) begin
      failed++;
      $display("FAIL midframe_reset_outputs: got %b, required 010000",
               {BCLK, LRCLK, SDATA, sample_req, underrun, overrun});
    end
    rst = 1'b0;
    wait_load(ur, cyc);
    tests++;
    if (cyc != 8) begin
      failed++;
      $display("FAIL post_reset_load_time: load after %0d clk, required 8", cyc);
    end
    tests++;
    if (ur !== 1'b1) begin
      failed++;
      $display("FAIL post_reset_underrun: underrun=%b, required 1", ur);
    end
    capture_frame(sd, lr);
    tests++;
    if (sd !== 64'h0) begin
      failed++;
      $display("FAIL post_reset_sdata: got %h, required 0", sd);
    end
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    rst      = 1'b1;
    VALID    = 1'b0;
    left_in  = '0;
    right_in = '0;
    test_reset;
    test_single;
    test_overrun;
    test_underrun;
    test_bypass;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
